// File: rtl/adc_cmd_ctrl.sv
// Host-command controller: parses 0xAA-framed UART commands into ADC config and sample strobes.
// Optional ack path back to the UART transmitter is built only when ADC_CMD_ACK_EN is defined.
module adc_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter int unsigned CH_W        = 3,
  parameter logic [15:0] DIV_DEF     = 16'd49,
  parameter logic [15:0] MIN_DIV     = 16'd9
) (
  input  logic            RST_clk,
  input  logic            RST,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [15:0]     adc_div,
  output logic [CH_W-1:0] adc_ch,
  output logic            adc_en,
  output logic            adc_sample,
  output logic            cfg_update,
  output logic            frame_err,
  output logic            cmd_err,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready
);

  localparam int unsigned GAP_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ARG_H,
    S_ARG_L,
    S_CSUM
  } state_t;

  state_t state_reg, state_next;

  logic [7:0]      cmd_reg, arg_h_reg, arg_l_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [15:0]     adc_div_reg;
  logic [CH_W-1:0] adc_ch_reg;
  logic            adc_en_reg;
  logic [15:0]     smp_cnt_reg;
  logic            adc_sample_reg;
  logic            cfg_update_reg;
  logic            frame_err_reg;
  logic            cmd_err_reg;

  logic            timeout;
  logic            frame_done;
  logic [15:0]     arg;
  logic [7:0]      csum_calc;
  logic            csum_ok;
  logic            cmd_known;
  logic            apply;
  logic            div_wr;
  logic            single_shot;
  logic            periodic;

  assign arg       = {arg_h_reg, arg_l_reg};
  assign csum_calc = cmd_reg + arg_h_reg + arg_l_reg;
  assign csum_ok   = (csum_calc == rx_data);
  assign cmd_known = (cmd_reg inside {[8'h01:8'h05]});
  assign apply     = frame_done && csum_ok && cmd_known;
  assign div_wr    = apply && (cmd_reg == 8'h01);
  assign single_shot = apply && (cmd_reg == 8'h05);
  assign periodic  = adc_en_reg && (smp_cnt_reg == adc_div_reg);

  always_ff @(posedge RST_clk) begin
    if (RST) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A received byte always takes priority over an expiring gap counter.
  always_comb begin
    state_next = state_reg;
    timeout    = 1'b0;
    frame_done = 1'b0;
    if (rx_valid) begin
      case (state_reg)
        S_IDLE:  if (rx_data == 8'hAA) state_next = S_CMD;
        S_CMD:   state_next = S_ARG_H;
        S_ARG_H: state_next = S_ARG_L;
        S_ARG_L: state_next = S_CSUM;
        S_CSUM: begin
          state_next = S_IDLE;
          frame_done = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
    end else if ((state_reg != S_IDLE) && (gap_cnt_reg == GAP_W'(TIMEOUT_CYC - 1))) begin
      timeout    = 1'b1;
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge RST_clk) begin
    if (RST) begin
      cmd_reg     <= '0;
      arg_h_reg   <= '0;
      arg_l_reg   <= '0;
      gap_cnt_reg <= '0;
    end else begin
      if (rx_valid || (state_reg == S_IDLE) || timeout) begin
        gap_cnt_reg <= '0;
      end else begin
        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
      end
      if (rx_valid) begin
        case (state_reg)
          S_CMD:   cmd_reg   <= rx_data;
          S_ARG_H: arg_h_reg <= rx_data;
          S_ARG_L: arg_l_reg <= rx_data;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge RST_clk) begin
    if (RST) begin
      adc_div_reg    <= DIV_DEF;
      adc_ch_reg     <= '0;
      adc_en_reg     <= 1'b0;
      cfg_update_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      cmd_err_reg    <= 1'b0;
    end else begin
      cfg_update_reg <= apply;
      frame_err_reg  <= timeout || (frame_done && !csum_ok);
      cmd_err_reg    <= frame_done && csum_ok && !cmd_known;
      if (apply) begin
        case (cmd_reg)
          8'h01: adc_div_reg <= (arg < MIN_DIV) ? MIN_DIV : arg;
          8'h02: adc_ch_reg  <= arg[CH_W-1:0];
          8'h03: adc_en_reg  <= 1'b1;
          8'h04: adc_en_reg  <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Counter is held at zero while disabled, so the enable edge always starts from zero.
  always_ff @(posedge RST_clk) begin
    if (RST) begin
      smp_cnt_reg    <= '0;
      adc_sample_reg <= 1'b0;
    end else begin
      adc_sample_reg <= periodic || single_shot;
      if (!adc_en_reg || div_wr || single_shot || periodic) begin
        smp_cnt_reg <= '0;
      end else begin
        smp_cnt_reg <= smp_cnt_reg + 16'd1;
      end
    end
  end

  assign adc_div    = adc_div_reg;
  assign adc_ch     = adc_ch_reg;
  assign adc_en     = adc_en_reg;
  assign adc_sample = adc_sample_reg;
  assign cfg_update = cfg_update_reg;
  assign frame_err  = frame_err_reg;
  assign cmd_err    = cmd_err_reg;

`ifdef ADC_CMD_ACK_EN
  logic [7:0] tx_data_reg;
  logic       tx_valid_reg;
  logic [7:0] ack_byte;

  assign ack_byte = !csum_ok ? 8'hE1 : (!cmd_known ? 8'hE2 : 8'h55);

  // A fresh ack overrides a handshake in the same cycle; timeouts never ack.
  always_ff @(posedge RST_clk) begin
    if (RST) begin
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
    end else if (frame_done) begin
      tx_data_reg  <= ack_byte;
      tx_valid_reg <= 1'b1;
    end else if (tx_valid_reg && tx_ready) begin
      tx_valid_reg <= 1'b0;
    end
  end

  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
`else
  logic tx_ready_unused;
  assign tx_ready_unused = tx_ready;
  assign tx_data  = 8'h00;
  assign tx_valid = 1'b0;
`endif

endmodule

// File: tb/tb_adc_cmd_ctrl.sv
// Directed bench for adc_cmd_ctrl: table of frames plus hand-written timing sequences.
module tb_adc_cmd_ctrl;
  localparam int TO = 60;

  logic       RST_clk = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic [15:0] adc_div;
  logic [2:0] adc_ch;
  logic       adc_en, adc_sample, cfg_update, frame_err, cmd_err;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks = 0;
  int failures = 0;
  int fe_cnt = 0;
  int cfg_cnt = 0;

  always #5 RST_clk = ~RST_clk;

  adc_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .RST_clk(RST_clk), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .adc_div(adc_div), .adc_ch(adc_ch), .adc_en(adc_en), .adc_sample(adc_sample),
    .cfg_update(cfg_update), .frame_err(frame_err), .cmd_err(cmd_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always @(negedge RST_clk) begin
    if (frame_err) fe_cnt++;
    if (cfg_update) cfg_cnt++;
  end

  typedef struct {
    logic [39:0] frame;
    logic [15:0] div;
    logic [2:0]  ch;
    logic        cfg;
    logic        ferr;
    logic        cerr;
    logic [7:0]  ack;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge RST_clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge RST_clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 4; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task automatic wait_sample(output int k);
    k = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge RST_clk);
      if (adc_sample) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic check_ack(input string name, input logic [7:0] ack);
`ifdef ADC_CMD_ACK_EN
    check({name, "_txd"}, tx_data, ack);
    check({name, "_txv"}, tx_valid, 1'b1);
`else
    check({name, "_txd"}, tx_data, 8'h00);
    check({name, "_txv"}, tx_valid, 1'b0);
`endif
  endtask

  initial begin
    int k;
    int snap_fe, snap_cfg;

    vecs[0] = '{40'hAA_01_00_63_64, 16'h0063, 3'd0, 1'b1, 1'b0, 1'b0, 8'h55};
    vecs[1] = '{40'hAA_01_00_63_65, 16'h0063, 3'd0, 1'b0, 1'b1, 1'b0, 8'hE1};
    vecs[2] = '{40'hAA_07_00_00_07, 16'h0063, 3'd0, 1'b0, 1'b0, 1'b1, 8'hE2};
    vecs[3] = '{40'hAA_01_00_02_03, 16'h0009, 3'd0, 1'b1, 1'b0, 1'b0, 8'h55};
    vecs[4] = '{40'hAA_AA_00_00_AA, 16'h0009, 3'd0, 1'b0, 1'b0, 1'b1, 8'hE2};
    vecs[5] = '{40'hAA_02_00_05_07, 16'h0009, 3'd5, 1'b1, 1'b0, 1'b0, 8'h55};
    vecs[6] = '{40'hAA_02_01_FE_01, 16'h0009, 3'd6, 1'b1, 1'b0, 1'b0, 8'h55};
    vecs[7] = '{40'hAA_01_00_63_64, 16'h0063, 3'd6, 1'b1, 1'b0, 1'b0, 8'h55};

    repeat (3) @(negedge RST_clk);
    RST = 1'b0;
    check("rst_div", adc_div, 16'd49);
    check("rst_ch", adc_ch, 3'd0);
    check("rst_en", adc_en, 1'b0);
    check("rst_pulses", {adc_sample, cfg_update, frame_err, cmd_err}, 4'b0000);
    check("rst_tx", {tx_valid, tx_data}, 9'h000);

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].frame);
      $display("vec %0d frame=%010h div=%04h ch=%0d cfg=%0b ferr=%0b cerr=%0b txv=%0b txd=%02h",
               v, vecs[v].frame, adc_div, adc_ch, cfg_update, frame_err, cmd_err, tx_valid, tx_data);
      check($sformatf("v%0d_div", v), adc_div, vecs[v].div);
      check($sformatf("v%0d_ch", v), adc_ch, vecs[v].ch);
      check($sformatf("v%0d_en", v), adc_en, 1'b0);
      check($sformatf("v%0d_cfg", v), cfg_update, vecs[v].cfg);
      check($sformatf("v%0d_ferr", v), frame_err, vecs[v].ferr);
      check($sformatf("v%0d_cerr", v), cmd_err, vecs[v].cerr);
      check($sformatf("v%0d_smp", v), adc_sample, 1'b0);
      check_ack($sformatf("v%0d", v), vecs[v].ack);
      @(negedge RST_clk);
      check($sformatf("v%0d_pulse_end", v), {cfg_update, frame_err, cmd_err}, 3'b000);
    end

    // Ack handshake: valid drops the cycle after tx_valid&tx_ready.
    tx_ready = 1'b1;
    @(negedge RST_clk);
    tx_ready = 1'b0;
    check("ack_drop_txv", tx_valid, 1'b0);
    $display("ack handshake txv=%0b", tx_valid);

    // Periodic sampling with div=0x63.
    send_frame(40'hAA_03_00_00_03);
    check("en_on", adc_en, 1'b1);
    check("en_smp0", adc_sample, 1'b0);
    wait_sample(k);
    $display("first strobe after %0d cycles", k);
    check("smp_first", k, 100);
    wait_sample(k);
    $display("second strobe after %0d cycles", k);
    check("smp_period", k, 100);

    // Single-shot while enabled restarts the period.
    send_frame(40'hAA_05_00_00_05);
    check("shot_en_smp", adc_sample, 1'b1);
    check("shot_en_cfg", cfg_update, 1'b1);
    wait_sample(k);
    $display("strobe after single-shot %0d cycles", k);
    check("shot_restart", k, 100);

    send_frame(40'hAA_04_00_00_04);
    check("en_off", adc_en, 1'b0);
    send_frame(40'hAA_05_00_00_05);
    check("shot_dis_smp", adc_sample, 1'b1);
    @(negedge RST_clk);
    check("shot_dis_one", adc_sample, 1'b0);
    wait_sample(k);
    $display("strobes while disabled k=%0d", k);
    check("no_smp_dis", k, -1);

    // Inter-byte timeout.
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h00);
    k = -1;
    for (int i = 1; i <= TO + 20; i++) begin
      @(negedge RST_clk);
      if (frame_err) begin
        k = i;
        break;
      end
    end
    $display("timeout frame_err after %0d cycles", k);
    check("timeout_cyc", k, TO);
    check("timeout_div", adc_div, 16'h0063);
    send_frame(40'hAA_02_00_05_07);
    $display("post-timeout frame ch=%0d", adc_ch);
    check("post_to_ch", adc_ch, 3'd5);

    // Byte on the last allowed cycle beats the timeout.
    #1 snap_fe = fe_cnt;
    send_byte(8'hAA);
    send_byte(8'h01);
    repeat (TO - 2) @(negedge RST_clk);
    send_byte(8'h00);
    send_byte(8'h0A);
    send_byte(8'h0B);
    check("edge_div", adc_div, 16'h000A);
    check("edge_cfg", cfg_update, 1'b1);
    @(negedge RST_clk);
    #1;
    $display("timeout-edge frame div=%04h fe_pulses=%0d", adc_div, fe_cnt - snap_fe);
    check("edge_no_ferr", fe_cnt - snap_fe, 0);

    // Reset mid-frame.
    send_frame(40'hAA_03_00_00_03);
    send_byte(8'hAA);
    send_byte(8'h01);
    #1 snap_fe = fe_cnt;
    @(negedge RST_clk);
    RST = 1'b1;
    @(negedge RST_clk);
    RST = 1'b0;
    #1 snap_cfg = cfg_cnt;
    check("mid_rst_div", adc_div, 16'd49);
    check("mid_rst_ch", adc_ch, 3'd0);
    check("mid_rst_en", adc_en, 1'b0);
    send_byte(8'h00);
    send_byte(8'h63);
    send_byte(8'h64);
    @(negedge RST_clk);
    #1;
    $display("after reset bytes div=%04h cfg_pulses=%0d fe_pulses=%0d",
             adc_div, cfg_cnt - snap_cfg, fe_cnt - snap_fe);
    check("ign_div", adc_div, 16'd49);
    check("ign_cfg", cfg_cnt - snap_cfg, 0);
    check("ign_ferr", fe_cnt - snap_fe, 0);

    // Junk before the sync byte is ignored.
    send_byte(8'h55);
    send_byte(8'h12);
    send_frame(40'hAA_02_00_03_05);
    $display("junk then frame ch=%0d", adc_ch);
    check("junk_ch", adc_ch, 3'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
